// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory request/ack
// handshake and fills the IF/ID register, with stall, redirect and a one-entry hold buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr
);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] DISCARD = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [31:0] old_addr_r;
    logic [31:0] buf_pc_r;
    logic [31:0] buf_instr_r;
    logic        ifid_valid_r;
    logic [31:0] ifid_pc_r;
    logic [31:0] ifid_pc4_r;
    logic [31:0] ifid_instr_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] buf_pc4_s;
    logic [31:0] redirect_tgt_s;
    logic [31:0] reset_pc_s;

    // Address arithmetic; pc+4 wraps naturally at 32 bits.
    always_comb begin
        pc_plus4_s     = pc_r + 32'd4;
        buf_pc4_s      = buf_pc_r + 32'd4;
        redirect_tgt_s = redirect_pc & WORD_MASK;
        reset_pc_s     = RESET_PC & WORD_MASK;
    end

    // While DISCARD waits out an abandoned request, the old address must stay on the bus.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_r;
        if (reset) begin
            imem_req = 1'b0;
        end else begin
            imem_req = (state_r != HOLD);
        end
        if (state_r == DISCARD) begin
            imem_addr = old_addr_r;
        end else begin
            imem_addr = pc_r;
        end
    end

    // PC, handshake state, hold buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= FETCH;
            pc_r         <= reset_pc_s;
            old_addr_r   <= 32'd0;
            buf_pc_r     <= 32'd0;
            buf_instr_r  <= 32'd0;
            ifid_valid_r <= 1'b0;
            ifid_pc_r    <= 32'd0;
            ifid_pc4_r   <= 32'd0;
            ifid_instr_r <= 32'd0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            pc_r         <= redirect_tgt_s;
                            ifid_valid_r <= 1'b0;
                        end else if (stall) begin
                            buf_pc_r    <= pc_r;
                            buf_instr_r <= imem_rdata;
                            pc_r        <= pc_plus4_s;
                            state_r     <= HOLD;
                        end else begin
                            ifid_pc_r    <= pc_r;
                            ifid_pc4_r   <= pc_plus4_s;
                            ifid_instr_r <= imem_rdata;
                            ifid_valid_r <= 1'b1;
                            pc_r         <= pc_plus4_s;
                        end
                    end else begin
                        if (redirect_valid) begin
                            old_addr_r   <= pc_r;
                            pc_r         <= redirect_tgt_s;
                            ifid_valid_r <= 1'b0;
                            state_r      <= DISCARD;
                        end else if (stall) begin
                            ifid_valid_r <= ifid_valid_r;
                        end else begin
                            ifid_valid_r <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_tgt_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (redirect_valid || !stall) begin
                        ifid_valid_r <= 1'b0;
                    end else begin
                        ifid_valid_r <= ifid_valid_r;
                    end
                    if (imem_ack) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= DISCARD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_r         <= redirect_tgt_s;
                        ifid_valid_r <= 1'b0;
                        state_r      <= FETCH;
                    end else if (!stall) begin
                        ifid_pc_r    <= buf_pc_r;
                        ifid_pc4_r   <= buf_pc4_s;
                        ifid_instr_r <= buf_instr_r;
                        ifid_valid_r <= 1'b1;
                        state_r      <= FETCH;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r      <= FETCH;
                    ifid_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ifid_valid = ifid_valid_r;
    assign ifid_pc    = ifid_pc_r;
    assign ifid_pc4   = ifid_pc4_r;
    assign ifid_instr = ifid_instr_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a variable-latency memory model for the main instance,
// and a second instance with a wrapping reset PC for the wrap and mid-request reset cases.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;

    int lat = 0;
    int wait_cnt = 0;

    assign imem_ack   = imem_req && (wait_cnt == lat);
    assign imem_rdata = imem_addr | 32'h0000_1000;

    // Memory model: ack after lat waiting cycles of a held request.
    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr)
    );

    logic        rst1 = 1'b1;
    logic        ack1_en = 1'b1;
    logic        req1;
    logic [31:0] addr1;
    logic        ack1;
    logic [31:0] rdata1;
    logic        v1;
    logic [31:0] pc1;
    logic [31:0] pc41;
    logic [31:0] instr1;

    assign ack1   = req1 && ack1_en;
    assign rdata1 = addr1 | 32'h0000_1000;

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(rst1), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack1), .imem_rdata(rdata1),
        .ifid_valid(v1), .ifid_pc(pc1),
        .ifid_pc4(pc41), .ifid_instr(instr1)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic reset0(input int l);
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        lat = l;
        cyc;
        cyc;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Reset + zero-wait fetch
        reset0(0);
        chk("s1_pc0_reg", ifid_pc, 32'd0);
        chk("s1_addr0", imem_addr, 32'h0);
        cyc;
        chk("s1_pc0", ifid_pc, 32'h0);
        chk("s1_ins0", ifid_instr, 32'h1000);
        chk("s1_pc4_0", ifid_pc4, 32'h4);
        chk("s1_v0", 32'(ifid_valid), 32'd1);
        cyc;
        chk("s1_pc1", ifid_pc, 32'h4);
        chk("s1_ins1", ifid_instr, 32'h1004);
        chk("s1_v1", 32'(ifid_valid), 32'd1);
        cyc;
        chk("s1_pc2", ifid_pc, 32'h8);
        chk("s1_ins2", ifid_instr, 32'h1008);
        chk("s1_v2", 32'(ifid_valid), 32'd1);

        // Wait states: ack two cycles after request
        reset0(2);
        chk("s2_v_c0", 32'(ifid_valid), 32'd0);
        cyc;
        chk("s2_v_c1", 32'(ifid_valid), 32'd0);
        cyc;
        chk("s2_v_c2", 32'(ifid_valid), 32'd0);
        cyc;
        chk("s2_pc0", ifid_pc, 32'h0);
        chk("s2_v_c3", 32'(ifid_valid), 32'd1);
        chk("s2_addr_a", imem_addr, 32'h4);
        cyc;
        chk("s2_v_c4", 32'(ifid_valid), 32'd0);
        chk("s2_addr_b", imem_addr, 32'h4);
        cyc;
        chk("s2_v_c5", 32'(ifid_valid), 32'd0);
        chk("s2_addr_c", imem_addr, 32'h4);
        cyc;
        chk("s2_pc1", ifid_pc, 32'h4);
        chk("s2_ins1", ifid_instr, 32'h1004);
        chk("s2_v_c6", 32'(ifid_valid), 32'd1);

        // Stall in the ack cycle for 0x8, held three cycles
        reset0(0);
        cyc;
        cyc;
        chk("s3_pc_pre", ifid_pc, 32'h4);
        chk("s3_addr8", imem_addr, 32'h8);
        stall = 1'b1;
        cyc;
        chk("s3_req_h1", 32'(imem_req), 32'd0);
        chk("s3_pc_h1", ifid_pc, 32'h4);
        cyc;
        chk("s3_req_h2", 32'(imem_req), 32'd0);
        chk("s3_ins_h2", ifid_instr, 32'h1004);
        chk("s3_v_h2", 32'(ifid_valid), 32'd1);
        cyc;
        chk("s3_req_h3", 32'(imem_req), 32'd0);
        chk("s3_pc_h3", ifid_pc, 32'h4);
        stall = 1'b0;
        cyc;
        chk("s3_pc8", ifid_pc, 32'h8);
        chk("s3_ins8", ifid_instr, 32'h1008);
        chk("s3_pc4_8", ifid_pc4, 32'hC);
        chk("s3_v8", 32'(ifid_valid), 32'd1);
        cyc;
        chk("s3_pcC", ifid_pc, 32'hC);
        chk("s3_insC", ifid_instr, 32'h100C);

        // Redirect while the request at 0x10 is pending
        reset0(0);
        repeat (4) cyc;
        chk("s4_addr10", imem_addr, 32'h10);
        chk("s4_pcC", ifid_pc, 32'hC);
        lat = 3;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        cyc;
        redirect_valid = 1'b0;
        chk("s4_addr_d1", imem_addr, 32'h10);
        chk("s4_req_d1", 32'(imem_req), 32'd1);
        chk("s4_v_d1", 32'(ifid_valid), 32'd0);
        cyc;
        chk("s4_addr_d2", imem_addr, 32'h10);
        cyc;
        chk("s4_addr_d3", imem_addr, 32'h10);
        chk("s4_v_d3", 32'(ifid_valid), 32'd0);
        cyc;
        chk("s4_addr200", imem_addr, 32'h200);
        chk("s4_v_f", 32'(ifid_valid), 32'd0);
        lat = 0;
        cyc;
        chk("s4_pc200", ifid_pc, 32'h200);
        chk("s4_ins200", ifid_instr, 32'h1200);
        chk("s4_v200", 32'(ifid_valid), 32'd1);

        // Redirect with stall while HOLD buffers 0x20
        reset0(0);
        repeat (8) cyc;
        chk("s5_addr20", imem_addr, 32'h20);
        stall = 1'b1;
        cyc;
        chk("s5_req_hold", 32'(imem_req), 32'd0);
        chk("s5_pc1C", ifid_pc, 32'h1C);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        cyc;
        redirect_valid = 1'b0;
        chk("s5_v_flush", 32'(ifid_valid), 32'd0);
        chk("s5_req", 32'(imem_req), 32'd1);
        chk("s5_addr100", imem_addr, 32'h100);
        stall = 1'b0;
        cyc;
        chk("s5_pc100", ifid_pc, 32'h100);
        chk("s5_ins100", ifid_instr, 32'h1100);
        chk("s5_v100", 32'(ifid_valid), 32'd1);

        // PC wrap and reset during a waiting request (second instance)
        reset = 1'b1;
        rst1 = 1'b1;
        ack1_en = 1'b1;
        cyc;
        rst1 = 1'b0;
        #1;
        chk("s6_addr_rst", addr1, 32'hFFFF_FFFC);
        cyc;
        chk("s6_addr_wrap", addr1, 32'h0);
        chk("s6_pc_top", pc1, 32'hFFFF_FFFC);
        chk("s6_pc4_wrap", pc41, 32'h0);
        chk("s6_v", 32'(v1), 32'd1);
        ack1_en = 1'b0;
        cyc;
        chk("s6_v_wait", 32'(v1), 32'd0);
        chk("s6_req_wait", 32'(req1), 32'd1);
        chk("s6_addr_wait", addr1, 32'h0);
        rst1 = 1'b1;
        #1;
        chk("s6_req_inrst", 32'(req1), 32'd0);
        cyc;
        chk("s6_req_rst", 32'(req1), 32'd0);
        chk("s6_v_rst", 32'(v1), 32'd0);
        chk("s6_pc_rst", pc1, 32'h0);
        rst1 = 1'b0;
        ack1_en = 1'b1;
        #1;
        chk("s6_req_rel", 32'(req1), 32'd1);
        chk("s6_addr_rel", addr1, 32'hFFFF_FFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
